// File: rtl/prbs5_checker.sv
// PRBS5 (x^5+x^2+1) serial stream checker: fill / search / flywheel-lock FSM
// with error pulse and saturating bit-error counter.
module prbs5_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       din,
  input  logic       din_vld,
  input  logic       clr_cnt,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_e;

  localparam logic [4:0] LOCK_CNT_W   = 5'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_ERR_W = 4'(UNLOCK_ERR);

  state_e     state_q,   state_d;
  logic [4:0] h_q,       h_d;
  logic [2:0] fill_q,    fill_d;
  logic [4:0] match_q,   match_d;
  logic [3:0] consec_q,  consec_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_q,     err_d;
  logic       locked_q,  locked_d;

  logic pred, miss, h_zero, fill_done, lock_hit, bit_err, unlock_hit;

  assign pred       = h_q[2] ^ h_q[4];
  assign miss       = din ^ pred;
  assign h_zero     = (h_q == '0);
  assign fill_done  = din_vld && (state_q == FILL) && (fill_q == 3'd4);
  assign lock_hit   = din_vld && (state_q == SEARCH) && !miss && !h_zero &&
                      ((match_q + 5'd1) == LOCK_CNT_W);
  assign bit_err    = din_vld && (state_q == LOCKED) && miss;
  assign unlock_hit = bit_err && ((consec_q + 4'd1) == UNLOCK_ERR_W);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= FILL;
      h_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      consec_q  <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      consec_q  <= consec_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_done)  state_d = SEARCH;
      SEARCH:  if (lock_hit)   state_d = LOCKED;
      LOCKED:  if (unlock_hit) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    h_d      = h_q;
    fill_d   = fill_q;
    match_d  = match_q;
    consec_d = consec_q;
    if (din_vld) begin
      unique case (state_q)
        FILL: begin
          h_d     = {h_q[3:0], din};
          fill_d  = fill_done ? '0 : fill_q + 3'd1;
          match_d = '0;
        end
        SEARCH: begin
          h_d      = {h_q[3:0], din};
          match_d  = (!miss && !h_zero && !lock_hit) ? match_q + 5'd1 : '0;
          consec_d = '0;
        end
        LOCKED: begin
          // flywheel: the prediction, not the line bit, advances the history
          h_d      = {h_q[3:0], pred};
          consec_d = miss ? consec_q + 4'd1 : '0;
          if (unlock_hit) begin
            h_d      = '0;
            fill_d   = '0;
            match_d  = '0;
            consec_d = '0;
          end
        end
        default: begin
          h_d      = '0;
          fill_d   = '0;
          match_d  = '0;
          consec_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_d     = bit_err;
    locked_d  = (state_d == LOCKED);
    err_cnt_d = err_cnt_q;
    if (clr_cnt)
      err_cnt_d = {7'd0, bit_err};
    else if (bit_err && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// Randomized bench for prbs5_checker: queue-based reference model plus
// directed lock / unlock / saturation / gap / reset scenarios.
module tb_prbs5_checker;

  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;
  localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       locked, err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit prbs [31];
  int tx_pos = 0;

  int m_mode, m_fill, m_match, m_consec, m_ecnt;
  bit m_hist [$];
  bit m_err, m_locked;

  prbs5_checker #(.LOCK_CNT(LOCK), .UNLOCK_ERR(UNLOCK)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .din     (din),
    .din_vld (din_vld),
    .clr_cnt (clr_cnt),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_FILL; m_fill = 0; m_match = 0; m_consec = 0; m_ecnt = 0;
    m_hist.delete();
    m_err = 1'b0; m_locked = 1'b0;
  endfunction

  // Reference: s[n] = s[n-3] ^ s[n-5], newest bit at the back of the queue.
  function automatic void model_step(input bit vld, input bit d, input bit clr);
    bit e = 1'b0;
    bit p, all_zero;
    if (vld) begin
      if (m_mode == M_FILL) begin
        m_hist.push_back(d);
        m_fill++;
        if (m_fill == 5) begin m_mode = M_SEARCH; m_match = 0; end
      end else begin
        p = m_hist[$-2] ^ m_hist[$-4];
        if (m_mode == M_SEARCH) begin
          all_zero = 1'b1;
          foreach (m_hist[k]) if (m_hist[k]) all_zero = 1'b0;
          m_match = (d == p && !all_zero) ? m_match + 1 : 0;
          m_hist.push_back(d);
          if (m_match == LOCK) begin m_mode = M_LOCKED; m_consec = 0; end
        end else begin
          m_hist.push_back(p);
          if (d != p) begin e = 1'b1; m_consec++; end
          else m_consec = 0;
          if (m_consec == UNLOCK) begin
            m_mode = M_FILL; m_hist.delete();
            m_fill = 0; m_match = 0; m_consec = 0;
          end
        end
      end
      while (m_hist.size() > 5) void'(m_hist.pop_front());
    end
    if (clr) m_ecnt = e ? 1 : 0;
    else if (e && m_ecnt < 255) m_ecnt++;
    m_err = e;
    m_locked = (m_mode == M_LOCKED);
  endfunction

  task automatic tick(input bit vld, input bit d, input bit clr);
    din_vld = vld; din = d; clr_cnt = clr;
    @(posedge clk);
    model_step(vld, d, clr);
    #1;
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("err_cnt", {24'd0, err_cnt}, m_ecnt);
  endtask

  task automatic send(input bit vld, input bit inject, input bit clr);
    bit d;
    if (vld) begin
      d = prbs[tx_pos] ^ inject;
      tx_pos = (tx_pos + 1) % 31;
    end else d = 1'($urandom);
    tick(vld, d, clr);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_reset();
    #1;
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_err_cnt", {24'd0, err_cnt}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    int vbits;
    bit got, v;
    prbs[0] = 1; prbs[1] = 1; prbs[2] = 1; prbs[3] = 0; prbs[4] = 0;
    for (int n = 5; n < 31; n++) prbs[n] = prbs[n-3] ^ prbs[n-5];

    #2;
    do_reset();

    // clean lock: lock visible right after the 13th sampled bit
    tx_pos = 0;
    for (int i = 0; i < 12; i++) send(1, 0, 0);
    check("lock_before_13", {31'd0, locked}, 0);
    send(1, 0, 0);
    check("lock_at_13", {31'd0, locked}, 1);
    for (int i = 13; i < 100; i++) send(1, 0, 0);
    check("clean_err_cnt", {24'd0, err_cnt}, 0);

    // single error while locked
    send(1, 1, 0);
    check("single_err_pulse", {31'd0, err}, 1);
    check("single_err_cnt", {24'd0, err_cnt}, 1);
    check("single_still_locked", {31'd0, locked}, 1);
    for (int i = 0; i < 10; i++) send(1, 0, 0);
    check("single_err_cnt_after", {24'd0, err_cnt}, 1);

    // loss of lock after 4 consecutive errors, then relock after 5+8 bits
    send(1, 0, 1);
    check("clr_cnt", {24'd0, err_cnt}, 0);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 0);
      check("unlock_err_pulse", {31'd0, err}, 1);
    end
    check("unlock_locked", {31'd0, locked}, 0);
    check("unlock_err_cnt", {24'd0, err_cnt}, 4);
    for (int i = 0; i < 12; i++) send(1, 0, 0);
    check("relock_before_13", {31'd0, locked}, 0);
    send(1, 0, 0);
    check("relock_at_13", {31'd0, locked}, 1);

    // all-zero input never locks
    do_reset();
    for (int i = 0; i < 200; i++) tick(1, 0, 0);
    check("zero_locked", {31'd0, locked}, 0);
    check("zero_err_cnt", {24'd0, err_cnt}, 0);

    // saturation then clear with a simultaneous error
    do_reset();
    for (int i = 0; i < 13; i++) send(1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      send(1, 1, 0);
      repeat ($urandom_range(1, 3)) send(1, 0, 0);
    end
    check("sat_err_cnt", {24'd0, err_cnt}, 255);
    check("sat_locked", {31'd0, locked}, 1);
    send(1, 1, 1);
    check("clr_with_err", {24'd0, err_cnt}, 1);

    // random din_vld gaps: lock counted in valid bits only
    do_reset();
    vbits = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      v = ($urandom_range(0, 2) != 0);
      send(v, 0, 0);
      if (v) vbits++;
      if (locked === 1'b1) got = 1;
    end
    check("gap_lock_bits", vbits, 13);
    for (int i = 0; i < 60; i++) send(($urandom_range(0, 2) != 0), 0, 0);
    check("gap_err_cnt", {24'd0, err_cnt}, 0);
    send(1, 1, 0);
    check("pre_rst_err_cnt", {24'd0, err_cnt}, 1);
    do_reset();

    // mixed random traffic: gaps, line errors, clears
    for (int i = 0; i < 3000; i++)
      send(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 31) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
